// File: rtl/hash_pkg.sv
// hash_pkg: state codes and round geometry shared by the
// hash round controller, the round tracker and their benches.
package hash_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BYTE  = 3'd1,
    LOAD       = 3'd2,
    ROUND_EXEC = 3'd3,
    FINAL_HASH = 3'd4,
    DONE       = 3'd5,
    ERROR      = 3'd6
  } state_t;

  localparam int ROUNDS = 36;
  localparam int STEPS  = 8;
  localparam int ROUND_CYCLES = ROUNDS * STEPS;

  localparam logic [2:0] FINAL_HASH_CODE = 3'd4;

endpackage

// File: rtl/hash_watchdog.sv
// hash_watchdog: per-visit cycle counter; expire is high for the
// single cycle where the count reaches limit-1 while enabled.
module hash_watchdog #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = en && (cnt == limit - W'(1));

endmodule

// File: rtl/hash_round_ctrl.sv
// hash_round_ctrl: accepts message bytes and sequences one round pass
// per byte through the tracker, then the final round and hash_valid.
module hash_round_ctrl
  import hash_pkg::*;
#(
  parameter int BYTE_W         = 8,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 320
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [BYTE_W-1:0] msg_data,
  output logic              msg_ready,
  input  logic              round_done,
  input  logic              final_round_done,
  output logic              round_exec_active,
  output logic              final_round_active,
  output logic [2:0]        state,
  output logic [2:0]        final_hash_state,
  output logic              load_en,
  output logic [BYTE_W-1:0] byte_q,
  output logic [LEN_W-1:0]  byte_count,
  output logic              hash_valid,
  output logic              busy,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t cur;
  state_t nxt;
  logic   last_q;
  logic   accept;
  logic   new_hash;
  logic   wd_en;
  logic   wd_clear;
  logic   wd_expire;

  assign wd_en    = (cur == ROUND_EXEC) || (cur == FINAL_HASH);
  assign wd_clear = (nxt != cur);

  hash_watchdog #(
    .W (WD_W)
  ) u_wd (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .en     (wd_en),
    .limit  (WD_W'(TIMEOUT_CYCLES)),
    .expire (wd_expire)
  );

  always_comb begin
    nxt      = cur;
    accept   = 1'b0;
    new_hash = 1'b0;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (cur)
        IDLE, ERROR: begin
          if (start) begin
            nxt      = WAIT_BYTE;
            new_hash = 1'b1;
          end
        end
        WAIT_BYTE: begin
          if (msg_valid) begin
            nxt    = LOAD;
            accept = 1'b1;
          end
        end
        LOAD: nxt = ROUND_EXEC;
        // done beats the watchdog on the boundary cycle
        ROUND_EXEC: begin
          if (round_done) begin
            nxt = last_q ? FINAL_HASH : WAIT_BYTE;
          end else if (wd_expire) begin
            nxt = ERROR;
          end
        end
        FINAL_HASH: begin
          if (final_round_done) begin
            nxt = DONE;
          end else if (wd_expire) begin
            nxt = ERROR;
          end
        end
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= IDLE;
      byte_q     <= '0;
      byte_count <= '0;
      last_q     <= 1'b0;
      err        <= 1'b0;
    end else begin
      cur <= nxt;
      if (new_hash) begin
        byte_count <= '0;
        last_q     <= 1'b0;
        err        <= 1'b0;
      end
      if (accept) begin
        byte_q <= msg_data;
        last_q <= msg_last;
        if (byte_count != '1) begin
          byte_count <= byte_count + LEN_W'(1);
        end
      end
      if (nxt == ERROR) begin
        err <= 1'b1;
      end
    end
  end

  assign state              = cur;
  assign final_hash_state   = FINAL_HASH_CODE;
  assign msg_ready          = (cur == WAIT_BYTE);
  assign load_en            = (cur == LOAD);
  assign round_exec_active  = (cur == ROUND_EXEC);
  assign final_round_active = (cur == FINAL_HASH);
  assign hash_valid         = (cur == DONE);
  assign busy = !((cur == IDLE) || (cur == DONE) || (cur == ERROR));

endmodule

// File: tb/tb_hash_round_ctrl.sv
// tb_hash_round_ctrl: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the controller.
module tb_hash_round_ctrl;
  import hash_pkg::*;

  localparam int TO = 320;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic        abort = 0;
  logic        msg_valid = 0;
  logic        msg_last = 0;
  logic [7:0]  msg_data = 0;
  logic        round_done;
  logic        final_round_done;
  logic        msg_ready;
  logic        round_exec_active;
  logic        final_round_active;
  logic [2:0]  state;
  logic [2:0]  final_hash_state;
  logic        load_en;
  logic [7:0]  byte_q;
  logic [15:0] byte_count;
  logic        hash_valid;
  logic        busy;
  logic        err;

  hash_round_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .msg_valid         (msg_valid),
    .msg_last          (msg_last),
    .msg_data          (msg_data),
    .msg_ready         (msg_ready),
    .round_done        (round_done),
    .final_round_done  (final_round_done),
    .round_exec_active (round_exec_active),
    .final_round_active(final_round_active),
    .state             (state),
    .final_hash_state  (final_hash_state),
    .load_en           (load_en),
    .byte_q            (byte_q),
    .byte_count        (byte_count),
    .hash_valid        (hash_valid),
    .busy              (busy),
    .err               (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  st;
    int          visit;
    logic [7:0]  bq;
    logic [15:0] cnt;
    logic        last;
    logic        err;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t model_next(mdl_t c);
    mdl_t n = c;
    bit   tmo = (c.visit == TO - 1);
    if (abort) begin
      n.st = 3'd0;
    end else begin
      case (c.st)
        3'd0, 3'd6: if (start) begin
          n.st = 3'd1; n.cnt = 0; n.err = 0; n.last = 0;
        end
        3'd1: if (msg_valid) begin
          n.st = 3'd2; n.bq = msg_data; n.last = msg_last;
          if (c.cnt != 16'hFFFF) n.cnt = c.cnt + 16'd1;
        end
        3'd2: n.st = 3'd3;
        3'd3: begin
          if (round_done) n.st = c.last ? 3'd4 : 3'd1;
          else if (tmo) begin n.st = 3'd6; n.err = 1; end
        end
        3'd4: begin
          if (final_round_done) n.st = 3'd5;
          else if (tmo) begin n.st = 3'd6; n.err = 1; end
        end
        default: n.st = 3'd0;
      endcase
    end
    n.visit = (n.st == c.st) ? c.visit + 1 : 0;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else m <= model_next(m);
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("state", state, m.st);
      chk("msg_ready", msg_ready, m.st == 3'd1);
      chk("load_en", load_en, m.st == 3'd2);
      chk("round_exec_active", round_exec_active, m.st == 3'd3);
      chk("final_round_active", final_round_active, m.st == 3'd4);
      chk("hash_valid", hash_valid, m.st == 3'd5);
      chk("busy", busy, (m.st >= 3'd1) && (m.st <= 3'd4));
      chk("err", err, m.err);
      chk("byte_q", byte_q, m.bq);
      chk("byte_count", byte_count, m.cnt);
      chk("final_hash_state", final_hash_state, 3'd4);
    end
  end

  // ---------------- tracker emulation ----------------
  int rlen_cfg = ROUND_CYCLES;
  int flen_cfg = STEPS;
  bit rnd_trk = 0;
  bit stray = 0;
  int stray_p = 4;
  int cur_r = 0, cur_f = 0, rc = 0, fc = 0;

  function automatic int pick();
    int r = $urandom_range(0, 29);
    if (r == 0) return 0;
    if (r == 1) return TO;
    return $urandom_range(1, 12);
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      rc = 0; fc = 0;
      round_done = 0; final_round_done = 0;
    end else begin
      if (round_exec_active) begin
        if (rc == 0) cur_r = rnd_trk ? pick() : rlen_cfg;
        rc++;
      end else rc = 0;
      if (final_round_active) begin
        if (fc == 0) cur_f = rnd_trk ? pick() : flen_cfg;
        fc++;
      end else fc = 0;
      round_done = (round_exec_active && cur_r != 0 && rc == cur_r) ||
                   (stray && !round_exec_active &&
                    $urandom_range(0, stray_p) == 0);
      final_round_done = (final_round_active && cur_f != 0 && fc == cur_f) ||
                         (stray && !final_round_active &&
                          $urandom_range(0, stray_p) == 0);
    end
  end

  // ---------------- activity monitor ----------------
  int re_cyc = 0, fr_cyc = 0, hv_cnt = 0;
  int re_vis = 0, fr_vis = 0, rdy_exec = 0;
  logic re_prev = 0, fr_prev = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      re_cyc += int'(round_exec_active);
      fr_cyc += int'(final_round_active);
      hv_cnt += int'(hash_valid);
      if (round_exec_active && !re_prev) re_vis++;
      if (final_round_active && !fr_prev) fr_vis++;
      if (round_exec_active && msg_ready) rdy_exec++;
    end
    re_prev = round_exec_active;
    fr_prev = final_round_active;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_state(input logic [2:0] code, input int budget,
                            input string nm);
    int i = 0;
    while (state !== code && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, state, code);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    wait_state(3'd1, 2000, "wait_ready");
    msg_valid = 1; msg_data = d; msg_last = last;
    @(negedge clk);
    msg_valid = 0; msg_last = 0;
  endtask

  int s_re, s_fr, s_hv, s_rv, s_fv, s_rdy;

  task automatic snap();
    s_re = re_cyc; s_fr = fr_cyc; s_hv = hv_cnt;
    s_rv = re_vis; s_fv = fr_vis; s_rdy = rdy_exec;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fhs", final_hash_state, FINAL_HASH_CODE);

    // single byte
    pulse_start();
    chk("t1_state_wait", state, 1);
    send(8'hA5, 1);
    chk("t1_load_en", load_en, 1);
    chk("t1_byte_q", byte_q, 8'hA5);
    snap();
    wait_state(3'd0, 400, "t1_idle");
    chk("t1_re_cycles", re_cyc - s_re, 288);
    chk("t1_fr_cycles", fr_cyc - s_fr, 8);
    chk("t1_hv", hv_cnt - s_hv, 1);
    chk("t1_count", byte_count, 1);

    // three bytes
    rlen_cfg = 30;
    pulse_start();
    snap();
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 1);
    wait_state(3'd0, 400, "t2_idle");
    chk("t2_re_visits", re_vis - s_rv, 3);
    chk("t2_fr_visits", fr_vis - s_fv, 1);
    chk("t2_rdy_in_exec", rdy_exec - s_rdy, 0);
    chk("t2_hv", hv_cnt - s_hv, 1);
    chk("t2_count", byte_count, 3);
    chk("t2_byte_q", byte_q, 8'h03);

    // watchdog timeout
    rlen_cfg = 0;
    pulse_start();
    send(8'h11, 0);
    snap();
    wait_state(3'd6, 400, "t3_error");
    chk("t3_re_cycles", re_cyc - s_re, TO);
    chk("t3_err", err, 1);
    chk("t3_enables", {round_exec_active, final_round_active,
                       msg_ready, load_en}, 0);
    repeat (3) @(negedge clk);
    chk("t3_err_hold", err, 1);
    pulse_start();
    chk("t3_restart", state, 1);
    chk("t3_err_clr", err, 0);
    rlen_cfg = 5;
    send(8'h22, 1);
    wait_state(3'd0, 100, "t3_idle");

    // done on the last watchdog cycle
    rlen_cfg = TO;
    flen_cfg = TO;
    pulse_start();
    send(8'h33, 1);
    snap();
    wait_state(3'd0, 1000, "t4_idle");
    chk("t4_re_cycles", re_cyc - s_re, TO);
    chk("t4_fr_cycles", fr_cyc - s_fr, TO);
    chk("t4_err", err, 0);
    chk("t4_hv", hv_cnt - s_hv, 1);

    // abort during the final round, start also high
    rlen_cfg = 4;
    flen_cfg = 0;
    pulse_start();
    send(8'h5C, 1);
    wait_state(3'd4, 50, "t5_final");
    repeat (2) @(negedge clk);
    snap();
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    chk("t5_idle", state, 0);
    chk("t5_fra", final_round_active, 0);
    stray_p = 0;
    stray = 1;
    repeat (5) @(negedge clk);
    stray = 0;
    stray_p = 4;
    chk("t5_stray_idle", state, 0);
    chk("t5_hv", hv_cnt - s_hv, 0);
    chk("t5_count", byte_count, 1);

    // async reset in the middle of a round pass
    rlen_cfg = ROUND_CYCLES;
    flen_cfg = STEPS;
    pulse_start();
    send(8'h44, 1);
    wait_state(3'd3, 10, "t6_exec");
    repeat (99) @(negedge clk);
    #3 reset_n = 0;
    #1;
    chk("t6_state", state, 0);
    chk("t6_rea", round_exec_active, 0);
    chk("t6_outs", {msg_ready, load_en, final_round_active,
                    hash_valid, busy, err}, 0);
    chk("t6_count", byte_count, 0);
    chk("t6_byte_q", byte_q, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    pulse_start();
    send(8'h66, 1);
    snap();
    wait_state(3'd0, 400, "t6_idle");
    chk("t6_hv", hv_cnt - s_hv, 1);
    chk("t6_re_cycles", re_cyc - s_re, 288);
    chk("t6_after_count", byte_count, 1);

    // random traffic against the model
    rnd_trk = 1;
    stray = 1;
    for (int c = 0; c < 6000; c++) begin
      start     = ($urandom_range(0, 19) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      msg_valid = ($urandom_range(0, 2) == 0);
      msg_data  = 8'($urandom);
      msg_last  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 0; abort = 0; msg_valid = 0; msg_last = 0;
    stray = 0;
    rnd_trk = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
